// File: rtl/ame_num_denormal_pkg.sv
// Shared types and widths for the AME denormaliser and its sequential left shifter.
package ame_num_denormal_pkg;

  localparam int unsigned AME_DATA_BITS      = 64;
  localparam int unsigned AME_DEN_SHIFT_STEP = 8;

  typedef enum logic [1:0] {
    DEN_IDLE,
    DEN_SHIFT,
    DEN_DONE
  } ame_den_state_t;

endpackage

// File: rtl/ame_num_denormal_sla_64b.sv
// Sequential unsigned left shifter: up to ShiftStep bits per clock, sticky flag for any
// set bit shifted out of the top. Same init/done level handshake as the right shifter.
module sla_64b
  import ame_num_denormal_pkg::*;
#(
  parameter int unsigned DataBits  = AME_DATA_BITS,
  parameter int unsigned ShiftStep = AME_DEN_SHIFT_STEP,
  parameter int unsigned ShiftBits = $clog2(DataBits)
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 init_i,
  input  logic [ShiftBits-1:0] shift_i,
  input  logic [DataBits-1:0]  data_i,
  output logic [DataBits-1:0]  data_o,
  output logic                 ovf_o,
  output logic                 done_o,
  output logic                 busy_o
);

  // Wide enough to hold ShiftStep itself, which may equal DataBits.
  localparam int unsigned StepBits = $clog2(DataBits + 1);
  localparam logic [StepBits-1:0] StepMax = StepBits'(ShiftStep);

  ame_den_state_t       state_q, state_d;
  logic [DataBits-1:0]  mag_q, mag_d;
  logic [ShiftBits-1:0] rem_q, rem_d;
  logic                 ovf_q, ovf_d;
  logic [StepBits-1:0]  rem_ext, step;
  logic [DataBits-1:0]  hi_mask;

  always_comb begin
    rem_ext = StepBits'(rem_q);
    step    = (rem_ext > StepMax) ? StepMax : rem_ext;
    // Top 'step' bits of the magnitude: anything set there is lost by this shift.
    hi_mask = ~({DataBits{1'b1}} >> step);

    state_d = state_q;
    mag_d   = mag_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;

    if (!init_i) begin
      state_d = DEN_IDLE;
      mag_d   = '0;
      rem_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        DEN_IDLE: begin
          state_d = DEN_SHIFT;
          mag_d   = data_i;
          rem_d   = shift_i;
          ovf_d   = 1'b0;
        end
        DEN_SHIFT: begin
          ovf_d = ovf_q | (|(mag_q & hi_mask));
          mag_d = mag_q << step;
          rem_d = rem_q - ShiftBits'(step);
          if (rem_d == '0) begin
            state_d = DEN_DONE;
          end
        end
        DEN_DONE: begin
          state_d = DEN_DONE;
        end
        default: begin
          state_d = DEN_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= DEN_IDLE;
      mag_q   <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
    end
  end

  assign data_o = mag_q;
  assign ovf_o  = ovf_q;
  assign done_o = (state_q == DEN_DONE);
  assign busy_o = (state_q != DEN_IDLE);

endmodule

// File: rtl/ame_num_denormal.sv
// AME denormaliser: signed x * 2^s via sign-magnitude multi-cycle left shift, saturating to
// the signed range. Output passes comp_data_i through unless init is high and result is done.
module ame_num_denormal
  import ame_num_denormal_pkg::*;
#(
  parameter int unsigned COMP_DATA_BITS = AME_DATA_BITS,
  parameter int unsigned SHIFT_STEP     = AME_DEN_SHIFT_STEP,
  parameter int unsigned SHIFT_BITS     = $clog2(COMP_DATA_BITS)
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      comp_init_i,
  output logic                      comp_done_o,
  input  logic [SHIFT_BITS-1:0]     comp_shift_i,
  input  logic [COMP_DATA_BITS-1:0] comp_data_i,
  output logic [COMP_DATA_BITS-1:0] comp_data_o,
  output logic                      comp_sat_o
);

  localparam int unsigned N = COMP_DATA_BITS;

  logic         sign_q, sign_d;
  logic [N-1:0] abs_in;
  logic [N-1:0] mag;
  logic         ovf, done, busy;
  logic         over_lim, sat;
  logic [N-1:0] sat_word, result;

  // Most negative input negates onto itself, which is exactly 2^(N-1) read as unsigned.
  assign abs_in = comp_data_i[N-1] ? (~comp_data_i + 1'b1) : comp_data_i;

  sla_64b #(
    .DataBits  (N),
    .ShiftStep (SHIFT_STEP),
    .ShiftBits (SHIFT_BITS)
  ) u_sla (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .init_i  (comp_init_i),
    .shift_i (comp_shift_i),
    .data_i  (abs_in),
    .data_o  (mag),
    .ovf_o   (ovf),
    .done_o  (done),
    .busy_o  (busy)
  );

  always_comb begin
    sign_d = sign_q;
    if (!comp_init_i) begin
      sign_d = 1'b0;
    end else if (!busy) begin
      sign_d = comp_data_i[N-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sign_q <= 1'b0;
    end else begin
      sign_q <= sign_d;
    end
  end

  // Negative results may reach 2^(N-1) in magnitude; positive ones only 2^(N-1)-1.
  always_comb begin
    over_lim = sign_q ? (mag[N-1] & (|mag[N-2:0])) : mag[N-1];
    sat      = done & (ovf | over_lim);
    sat_word = sign_q ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    if (sat) begin
      result = sat_word;
    end else if (sign_q) begin
      result = ~mag + 1'b1;
    end else begin
      result = mag;
    end
  end

  assign comp_done_o = done;
  assign comp_sat_o  = sat;
  assign comp_data_o = (comp_init_i && done) ? result : comp_data_i;

endmodule

// File: tb/tb_ame_num_denormal.sv
// Scoreboarded bench for ame_num_denormal; three instances with SHIFT_STEP 1, 8 and 64.
module tb_ame_num_denormal;

  localparam int N = 64;
  localparam int STEPS [3] = '{1, 8, 64};
  localparam logic signed [127:0] MaxP = 128'sh7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [127:0] MinP = -MaxP - 128'sd1;

  typedef struct {
    logic [N-1:0] data;
    logic         sat;
    logic [5:0]   s;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         init = 1'b0;
  logic [5:0]   shift = '0;
  logic [N-1:0] din = '0;
  logic [N-1:0] dout [3];
  logic         done [3];
  logic         sat  [3];

  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  ame_num_denormal #(.COMP_DATA_BITS(N), .SHIFT_STEP(1)) u_dut_s1 (
    .clk_i(clk), .rst_n_i(rst_n), .comp_init_i(init), .comp_done_o(done[0]),
    .comp_shift_i(shift), .comp_data_i(din), .comp_data_o(dout[0]), .comp_sat_o(sat[0])
  );
  ame_num_denormal #(.COMP_DATA_BITS(N), .SHIFT_STEP(8)) u_dut_s8 (
    .clk_i(clk), .rst_n_i(rst_n), .comp_init_i(init), .comp_done_o(done[1]),
    .comp_shift_i(shift), .comp_data_i(din), .comp_data_o(dout[1]), .comp_sat_o(sat[1])
  );
  ame_num_denormal #(.COMP_DATA_BITS(N), .SHIFT_STEP(64)) u_dut_s64 (
    .clk_i(clk), .rst_n_i(rst_n), .comp_init_i(init), .comp_done_o(done[2]),
    .comp_shift_i(shift), .comp_data_i(din), .comp_data_o(dout[2]), .comp_sat_o(sat[2])
  );

  function automatic exp_t model(input logic [N-1:0] d, input logic [5:0] s);
    logic signed [127:0] p;
    exp_t e;
    p = {{64{d[N-1]}}, d};
    p = p <<< s;
    e.s = s;
    if (p > MaxP) begin
      e.data = 64'h7FFF_FFFF_FFFF_FFFF;
      e.sat  = 1'b1;
    end else if (p < MinP) begin
      e.data = 64'h8000_0000_0000_0000;
      e.sat  = 1'b1;
    end else begin
      e.data = p[N-1:0];
      e.sat  = 1'b0;
    end
    return e;
  endfunction

  function automatic int lat(input int s, input int step);
    int c;
    c = (s + step - 1) / step;
    return ((c < 1) ? 1 : c) + 1;
  endfunction

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [N-1:0] d, input logic [5:0] s);
    exp_t e;
    int   seen [3];
    e = model(d, s);
    sb.push_back(e);
    din   = d;
    shift = s;
    init  = 1'b1;
    seen  = '{0, 0, 0};
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) begin
        din   = {$urandom, $urandom};
        shift = 6'($urandom);
      end
      for (int i = 0; i < 3; i++) begin
        if (seen[i] == 0 && done[i]) seen[i] = c;
      end
      if (seen[0] != 0 && seen[1] != 0 && seen[2] != 0) break;
    end
    e = sb.pop_front();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("latency step%0d d=%0h s=%0d", STEPS[i], d, e.s),
            64'(seen[i]), 64'(lat(int'(e.s), STEPS[i])));
      check($sformatf("data step%0d d=%0h s=%0d", STEPS[i], d, e.s), dout[i], e.data);
      check($sformatf("sat step%0d d=%0h s=%0d", STEPS[i], d, e.s), 64'(sat[i]), 64'(e.sat));
    end
    init = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("release done step%0d", STEPS[i]), 64'(done[i]), 64'd0);
      check($sformatf("release pass step%0d", STEPS[i]), dout[i], din);
    end
  endtask

  initial begin
    logic [N-1:0] rd;

    din = 64'd5;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset done step%0d", STEPS[i]), 64'(done[i]), 64'd0);
      check($sformatf("reset sat step%0d", STEPS[i]), 64'(sat[i]), 64'd0);
      check($sformatf("reset pass step%0d", STEPS[i]), dout[i], din);
    end
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op(64'd5, 6'd3);
    run_op(-64'sd3, 6'd20);
    run_op(64'h4000_0000_0000_0000, 6'd1);
    run_op(64'd1, 6'd63);
    run_op(-64'sd1, 6'd63);
    run_op(64'h8000_0000_0000_0000, 6'd0);
    run_op(64'h8000_0000_0000_0000, 6'd1);
    run_op(64'd0, 6'd63);
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 6'd0);

    // Abort mid-shift, then restart with full latency.
    din   = 64'd99;
    shift = 6'd40;
    init  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("abort done before drop", 64'(done[1]), 64'd0);
    init = 1'b0;
    din  = 64'h1234;
    @(posedge clk);
    #1;
    check("abort done after drop", 64'(done[1]), 64'd0);
    check("abort passthrough", dout[1], din);
    run_op(64'h1234, 6'd40);

    // Reset while shifting.
    din   = 64'd123;
    shift = 6'd40;
    init  = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst shift done", 64'(done[1]), 64'd0);
    check("rst shift sat", 64'(sat[1]), 64'd0);
    init = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset while holding a saturated result.
    din   = 64'd1;
    shift = 6'd63;
    init  = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("pre-rst done", 64'(done[1]), 64'd1);
    check("pre-rst sat", 64'(sat[1]), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst done", 64'(done[1]), 64'd0);
    check("rst sat", 64'(sat[1]), 64'd0);
    check("rst pass", dout[1], din);
    init = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op(64'd7, 6'd8);

    for (int k = 0; k < 24; k++) begin
      rd = {$urandom, $urandom};
      rd = 64'($signed(rd) >>> $urandom_range(0, 63));
      run_op(rd, 6'($urandom_range(0, 63)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
